mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Iterative shift-add multiply sequencer in the EX stage, beside the ALU.
- When the EX-stage ALU control code is MUL (4'b1011), it captures both operands and runs one add/shift per cycle.
- While it runs, it stalls the pipeline. It then presents the low WIDTH bits of the product for exactly one cycle.
- Other ALU operations pass through untouched; this block only drives stall/result for MUL.

Parameters:
- WIDTH, 32, operand and result width in bits.
- MUL_CODE, 4'b1011, ALU control code that selects this unit.
- CNT_W, 5, counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  the EX stage holds a real (non-bubble) instruction.
- flush_i  input  1  the EX instruction is squashed; abort any operation.
- ALUCtrl_i  input  4  ALU control code of the EX instruction.
- src1_i  input  WIDTH  multiplicand (rs).
- src2_i  input  WIDTH  multiplier (rt).
- stall_o  output  1  freezes the PC, IF/ID and ID/EX, and holds the EX instruction.
- busy_o  output  1  registered; high in the BUSY state.
- done_o  output  1  registered; one-cycle pulse, result_o valid.
- result_o  output  WIDTH  low WIDTH bits of src1*src2; held between operations.

Behaviour:
- start = valid_i & (ALUCtrl_i == MUL_CODE) & ~flush_i.
- States:
  - IDLE: waits for start.
  - BUSY: one partial product per cycle.
  - DONE: result presented for one cycle.
- Internal registers: acc (WIDTH), mcand (WIDTH), mplr (WIDTH), cnt (CNT_W).
- Reset (rst_i=1 at an edge): state=IDLE, acc=0, mcand=0, mplr=0, cnt=0, result_o=0, done_o=0, busy_o=0. Reset has priority over every other input, including mid-BUSY.
- IDLE:
  - On start: mcand<=src1_i, mplr<=src2_i, acc<=0, cnt<=0, go to BUSY.
  - Otherwise stay.
- BUSY, each cycle:
  - If mplr[0], acc <= acc + mcand, truncated to WIDTH bits (carry discarded).
  - mcand <= mcand << 1; mplr <= mplr >> 1; cnt <= cnt + 1.
  - Go to DONE when cnt == WIDTH-1 or (mplr >> 1) == 0.
  - On that same edge, result_o <= final acc (including this cycle's add) and done_o <= 1.
- DONE:
  - done_o=1 for this single cycle; next state IDLE; done_o returns to 0.
  - start is ignored in DONE, because the same instruction is still in EX.
- stall_o (combinational):
  - 1 in IDLE when start is high.
  - 1 throughout BUSY unless flush_i is high.
  - 0 in DONE, so the instruction advances with result_o at the end of the DONE cycle.
- Latency: the number of BUSY cycles is the bit position of src2's highest set bit plus one, minimum 1.
  - src2=0 gives 1 BUSY cycle.
  - src2=0xFFFFFFFF gives 32 BUSY cycles.
  - Total stalled cycles = BUSY cycles + 1, counting the accept cycle.
- Signedness: the low WIDTH bits are identical for signed and unsigned operands, so no sign handling is required.
- Flush: flush_i=1 in BUSY or DONE moves the state to IDLE on the next edge.
  - done_o is not asserted; result_o keeps its previous value.
  - acc, mcand, mplr and cnt are don't-care after the abort.
  - In IDLE, flush_i suppresses start.
- Operands are sampled only at accept. Changes on src1_i/src2_i while BUSY have no effect.
- Back-to-back MUL: the second MUL is accepted in the IDLE cycle that follows DONE, so there is always exactly one non-stalled cycle between two MULs.
- A non-MUL code, or valid_i=0, in IDLE leaves all outputs unchanged and stall_o=0.

Test Plan:
1. Reset, then src1=7, src2=5 MUL -> stall_o high at accept; 3 BUSY cycles; done_o pulses with result_o=35 (0x23); stall_o low in the DONE cycle.
2. src1=0x12345678, src2=0 -> 1 BUSY cycle, result_o=0, 2 stalled cycles total. Then src1=0xFFFFFFFF, src2=0xFFFFFFFF -> 32 BUSY cycles, result_o=0x00000001.
3. Signed case src1=0xFFFFFFFD (-3), src2=6 -> result_o=0xFFFFFFEE (-18). Overflow case src1=0x80000000, src2=2 -> result_o=0x00000000.
4. Assert flush_i on the 2nd BUSY cycle of 0x10*0x100 -> IDLE next edge, no done_o, result_o keeps its prior value, stall_o low while flush_i is high.
5. Pulse rst_i mid-BUSY -> next cycle all outputs 0, state IDLE. A following MUL 3*4 -> result_o=12.
6. Two MULs back-to-back (3*3, then 4*4), with start held through DONE -> second accepted only after DONE; done_o pulses give 9 then 16. ADD code (4'b0010) with valid_i=1 -> stall_o stays 0.

Source files
------------

// File: rtl/mul_seq_ctrl_if.sv
// EX-stage multiply sequencer bus: operands and control in, stall/result out.
interface mul_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             flush_i;
  logic [3:0]       ALUCtrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  // Pipeline side drives the instruction and consumes stall/result.
  modport master (
    output valid_i, flush_i, ALUCtrl_i, src1_i, src2_i,
    input  stall_o, busy_o, done_o, result_o
  );

  // Sequencer side.
  modport slave (
    input  valid_i, flush_i, ALUCtrl_i, src1_i, src2_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add multiplier for the EX stage. Captures operands on a MUL,
// retires one multiplier bit per cycle while stalling the pipe, then presents
// the low WIDTH bits of the product for exactly one cycle.
module mul_seq_ctrl #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] MUL_CODE = 4'b1011,
  parameter int         CNT_W    = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mul_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             stall;
  logic             start;
  logic [WIDTH-1:0] acc_sum;

  assign start = bus.valid_i & (bus.ALUCtrl_i == MUL_CODE) & ~bus.flush_i;
  // Accumulator value including this cycle's partial product.
  assign acc_sum = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

  // Next-state, datapath and stall decode.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    stall    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall = start;
        if (start) begin
          mcand_d = bus.src1_i;
          mplr_d  = bus.src2_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.flush_i) begin
          // Abort: no done pulse, result_o keeps its old value.
          state_d = S_IDLE;
        end else begin
          stall   = 1'b1;
          acc_d   = acc_sum;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          // Stop early once no multiplier bits remain.
          if (cnt_q == CNT_W'(WIDTH-1) || (mplr_q >> 1) == '0) begin
            state_d  = S_DONE;
            result_d = acc_sum;
            done_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        // Same instruction still sits in EX, so start is ignored here.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_BUSY);
  end

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.stall_o  = stall;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: latency, products, flush, reset, back-to-back.
module tb_mul_seq_ctrl;
  localparam logic [3:0] MUL = 4'b1011;
  localparam logic [3:0] ADD = 4'b0010;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  mul_seq_ctrl_if #(.WIDTH(32)) bus ();

  mul_seq_ctrl #(.WIDTH(32), .MUL_CODE(MUL), .CNT_W(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one MUL and follow it to DONE. With hold=1 the start request stays
  // asserted through DONE so the caller can chain a second MUL.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_busy, input bit hold);
    int nb;
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = MUL;
    bus.src1_i    = a;
    bus.src2_i    = b;
    #1;
    chk("stall_accept", 32'(bus.stall_o), 32'd1);
    step();
    // Operands must already be latched; scramble the inputs.
    bus.src1_i = 32'hDEADBEEF;
    bus.src2_i = 32'hFFFF0000;
    nb = 0;
    while (bus.busy_o && nb < 40) begin
      if (!bus.stall_o) begin
        n_chk++; n_err++;
        $display("FAIL stall_busy: got 0 expected 1 at busy cycle %0d", nb);
      end
      nb++;
      step();
    end
    chk("busy_cycles", 32'(nb), 32'(exp_busy));
    chk("done_pulse", 32'(bus.done_o), 32'd1);
    chk("result", bus.result_o, exp_res);
    chk("stall_done", 32'(bus.stall_o), 32'd0);
    if (!hold) bus.valid_i = 1'b0;
    step();
    chk("done_drop", 32'(bus.done_o), 32'd0);
    chk("busy_after", 32'(bus.busy_o), 32'd0);
    chk("stall_after", 32'(bus.stall_o), 32'(hold));
  endtask

  initial begin
    rst           = 1'b1;
    bus.valid_i   = 1'b0;
    bus.flush_i   = 1'b0;
    bus.ALUCtrl_i = 4'h0;
    bus.src1_i    = '0;
    bus.src2_i    = '0;
    step(); step();
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_result", bus.result_o, 32'd0);
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    rst = 1'b0;
    step();

    // Basic, zero multiplier, full width, signed, overflow.
    run_mul(32'd7, 32'd5, 32'd35, 3, 1'b0);
    run_mul(32'h12345678, 32'd0, 32'd0, 1, 1'b0);
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32, 1'b0);
    run_mul(32'hFFFFFFFD, 32'd6, 32'hFFFFFFEE, 3, 1'b0);
    run_mul(32'd9, 32'd9, 32'd81, 4, 1'b0);
    run_mul(32'h80000000, 32'd2, 32'h00000000, 2, 1'b0);

    // Flush on the second BUSY cycle of 0x10*0x100.
    bus.valid_i = 1'b1; bus.ALUCtrl_i = MUL;
    bus.src1_i = 32'h10; bus.src2_i = 32'h100;
    step();            // BUSY cycle 1
    chk("flush_busy1", 32'(bus.busy_o), 32'd1);
    step();            // BUSY cycle 2
    bus.flush_i = 1'b1;
    #1;
    chk("flush_stall", 32'(bus.stall_o), 32'd0);
    step();
    chk("flush_idle", 32'(bus.busy_o), 32'd0);
    chk("flush_nodone", 32'(bus.done_o), 32'd0);
    chk("flush_result", bus.result_o, 32'd0);
    chk("flush_nostart", 32'(bus.stall_o), 32'd0);
    bus.flush_i = 1'b0; bus.valid_i = 1'b0;
    step();
    chk("flush_nodone2", 32'(bus.done_o), 32'd0);
    run_mul(32'd6, 32'd7, 32'd42, 3, 1'b0);

    // Reset mid-BUSY.
    bus.valid_i = 1'b1; bus.ALUCtrl_i = MUL;
    bus.src1_i = 32'd5; bus.src2_i = 32'h80;
    step(); step(); step();
    chk("pre_rst_busy", 32'(bus.busy_o), 32'd1);
    rst = 1'b1; bus.valid_i = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy_o), 32'd0);
    chk("midrst_done", 32'(bus.done_o), 32'd0);
    chk("midrst_result", bus.result_o, 32'd0);
    chk("midrst_stall", 32'(bus.stall_o), 32'd0);
    run_mul(32'd3, 32'd4, 32'd12, 3, 1'b0);

    // Back-to-back with start held through DONE.
    run_mul(32'd3, 32'd3, 32'd9, 2, 1'b1);
    run_mul(32'd4, 32'd4, 32'd16, 3, 1'b0);

    // Non-MUL op never stalls.
    bus.valid_i = 1'b1; bus.ALUCtrl_i = ADD;
    bus.src1_i = 32'd1; bus.src2_i = 32'd2;
    #1;
    chk("add_stall", 32'(bus.stall_o), 32'd0);
    step();
    chk("add_busy", 32'(bus.busy_o), 32'd0);
    chk("add_result", bus.result_o, 32'd16);
    // MUL code without valid is a bubble.
    bus.valid_i = 1'b0; bus.ALUCtrl_i = MUL;
    #1;
    chk("bubble_stall", 32'(bus.stall_o), 32'd0);
    step();
    chk("bubble_busy", 32'(bus.busy_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
